// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - request/completion bus of the multicycle ALU
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUOp;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             div_by_zero;

  modport master (
    output start, A, B, ALUOp,
    input  ready, busy, done, Result, Zero, div_by_zero
  );

  modport slave (
    input  start, A, B, ALUOp,
    output ready, busy, done, Result, Zero, div_by_zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - clocked ALU; MUL/DIVU/REMU iterate one bit per cycle
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  multicycle_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_MUL  = 4'b0000;
  localparam logic [3:0] OP_DIVU = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_ADD  = 4'b1010;
  localparam logic [3:0] OP_SUB  = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [SHW-1:0]       cnt;
  logic [3:0]           op;
  logic [2*WIDTH-1:0]   acc, mcand, acc_step;
  logic [WIDTH-1:0]     mplier, quo, divisor, quo_step;
  logic [WIDTH:0]       rem, rem_step;
  logic [WIDTH+1:0]     shifted, trial;
  logic                 qbit, last, iter_op, b_zero, div_op;
  logic [SHW-1:0]       sh;
  logic [WIDTH-1:0]     alu_res, res_d, result_q;
  logic                 load, dbz_d, zero_q, dbz_q;

  assign sh      = bus.B[SHW-1:0];
  assign b_zero  = (bus.B == '0);
  assign div_op  = (bus.ALUOp == OP_DIVU) || (bus.ALUOp == OP_REMU);
  assign iter_op = (bus.ALUOp == OP_MUL) || div_op;
  assign last    = (cnt == SHW'(WIDTH - 1));

  // One shift-add step and one restoring-division step per cycle
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial    = shifted - {2'b00, divisor};
  assign qbit     = ~trial[WIDTH+1];
  assign rem_step = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign quo_step = {quo[WIDTH-2:0], qbit};

  // Single-cycle results from the live inputs; DIVU/REMU only reach here with B=0
  always_comb begin
    alu_res = '0;
    case (bus.ALUOp)
      OP_REMU: alu_res = bus.A;
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_SLL:  alu_res = bus.A << sh;
      OP_SRL:  alu_res = bus.A >> sh;
      OP_SRA:  alu_res = $unsigned($signed(bus.A) >>> sh);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_ADD:  alu_res = bus.A + bus.B;
      OP_SUB:  alu_res = bus.A - bus.B;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    res_d     = '0;
    dbz_d     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (iter_op && !b_zero) begin
            state_nxt = (bus.ALUOp == OP_MUL) ? S_MUL : S_DIV;
          end else begin
            state_nxt = S_DONE;
            load      = 1'b1;
            res_d     = alu_res;
            dbz_d     = div_op && b_zero;
          end
        end
      end
      S_MUL: begin
        if (last) begin
          state_nxt = S_DONE;
          load      = 1'b1;
          res_d     = acc_step[WIDTH-1:0];
        end
      end
      S_DIV: begin
        if (last) begin
          state_nxt = S_DONE;
          load      = 1'b1;
          res_d     = (op == OP_REMU) ? rem_step[WIDTH-1:0] : quo_step;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op       <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
    end else begin
      if (load) begin
        result_q <= res_d;
        zero_q   <= (res_d == '0);
        dbz_q    <= dbz_d;
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op      <= bus.ALUOp;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, bus.A};
            mplier  <= bus.B;
            rem     <= '0;
            quo     <= bus.A;
            divisor <= bus.B;
          end
        end
        S_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        S_DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = (state == S_IDLE);
  assign bus.busy        = (state == S_MUL) || (state == S_DIV);
  assign bus.done        = (state == S_DONE);
  assign bus.Result      = result_q;
  assign bus.Zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed bench for multicycle_alu at WIDTH=32 and WIDTH=8
module tb_multicycle_alu;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(32)) bus32();
  multicycle_alu_if #(.WIDTH(8))  bus8();

  multicycle_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  multicycle_alu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp_edges: clock edges after the accepting edge until done; 0 means done in the next cycle
  task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic exp_dbz,
                       input int exp_edges, input bit spam);
    int w, edges, busy_cnt;
    w = 0;
    while (!bus32.ready && w < 100) begin @(posedge clk); #1; w++; end
    chk({tag, "_ready"}, bus32.ready, 1);
    bus32.start = 1'b1; bus32.ALUOp = op; bus32.A = a; bus32.B = b;
    @(posedge clk); #1;
    bus32.start = 1'b0; bus32.ALUOp = 4'b0100; bus32.A = ~a; bus32.B = $urandom;
    edges = 0; busy_cnt = 0;
    while (!bus32.done && edges < 200) begin
      if (bus32.busy) busy_cnt++;
      if (spam) begin
        bus32.start = 1'b1; bus32.ALUOp = 4'b1010; bus32.A = $urandom; bus32.B = $urandom;
      end
      @(posedge clk); #1;
      edges++;
    end
    bus32.start = 1'b0;
    chk({tag, "_done"},   bus32.done, 1);
    chk({tag, "_edges"},  edges, exp_edges);
    chk({tag, "_busy"},   busy_cnt, exp_edges);
    chk({tag, "_result"}, bus32.Result, exp);
    chk({tag, "_zero"},   bus32.Zero, (exp == 32'h0));
    chk({tag, "_dbz"},    bus32.div_by_zero, exp_dbz);
  endtask

  task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp, input int exp_edges);
    int edges;
    bus8.start = 1'b1; bus8.ALUOp = op; bus8.A = a; bus8.B = b;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00;
    edges = 0;
    while (!bus8.done && edges < 50) begin @(posedge clk); #1; edges++; end
    chk({tag, "_done"},   bus8.done, 1);
    chk({tag, "_edges"},  edges, exp_edges);
    chk({tag, "_result"}, bus8.Result, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] xa, xb;
    bus32.start = 1'b0; bus32.A = '0; bus32.B = '0; bus32.ALUOp = '0;
    bus8.start  = 1'b0; bus8.A  = '0; bus8.B  = '0; bus8.ALUOp  = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready",  bus32.ready, 1);
    chk("rst_busy",   bus32.busy, 0);
    chk("rst_done",   bus32.done, 0);
    chk("rst_result", bus32.Result, 0);
    chk("rst_zero",   bus32.Zero, 1);
    chk("rst_dbz",    bus32.div_by_zero, 0);

    // MUL with new requests pulsed every busy cycle; none may be queued
    run32("mul_7x6", 4'b0000, 32'd7, 32'd6, 32'd42, 1'b0, 32, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_done",   bus32.done, 0);
      chk("hold_result", bus32.Result, 32'd42);
      chk("hold_zero",   bus32.Zero, 0);
    end

    // Reset ten cycles into a MUL
    bus32.start = 1'b1; bus32.ALUOp = 4'b0000; bus32.A = 32'd7; bus32.B = 32'd6;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_ready",  bus32.ready, 1);
    chk("abort_busy",   bus32.busy, 0);
    chk("abort_done",   bus32.done, 0);
    chk("abort_result", bus32.Result, 0);
    chk("abort_zero",   bus32.Zero, 1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_nodone", bus32.done, 0);
    end

    run32("divu_100_7", 4'b0001, 32'd100, 32'd7, 32'd14, 1'b0, 32, 1'b0);
    run32("remu_100_7", 4'b1100, 32'd100, 32'd7, 32'd2,  1'b0, 32, 1'b0);
    run32("divu_by0",   4'b0001, 32'd5,   32'd0, 32'd0,  1'b1, 0,  1'b0);
    run32("remu_by0",   4'b1100, 32'd5,   32'd0, 32'd5,  1'b1, 0,  1'b0);
    run32("add_clrdbz", 4'b1010, 32'd1,   32'd2, 32'd3,  1'b0, 0,  1'b0);
    run32("sra_31",     4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    run32("slt_neg",    4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0, 1'b0);
    run32("sltu_big",   4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 1'b0);
    run32("sub_eq",     4'b1011, 32'd3, 32'd3, 32'd0, 1'b0, 0, 1'b0);
    run32("add_wrap",   4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 1'b0);
    run32("mul_wrap",   4'b0000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 32, 1'b0);
    run32("sll_sh0",    4'b0101, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 0, 1'b0);
    run32("srl_4",      4'b0110, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 0, 1'b0);
    run32("and",        4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 0, 1'b0);
    run32("or",         4'b0011, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 0, 1'b0);
    run32("op_1111",    4'b1111, 32'd5, 32'd5, 32'd0, 1'b0, 0, 1'b0);
    run32("mul_b0",     4'b0000, 32'd9, 32'd0, 32'd0, 1'b0, 0, 1'b0);

    // Back-to-back XOR with start held high: one completion every second cycle
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.ALUOp = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      xa = 32'h1111_1111 * (k + 1);
      xb = 32'h0F0F_00FF << k;
      bus32.A = xa; bus32.B = xb;
      @(posedge clk); #1;
      chk("xor_done",   bus32.done, 1);
      chk("xor_result", bus32.Result, xa ^ xb);
      @(posedge clk); #1;
      chk("xor_gap",    bus32.done, 0);
      chk("xor_ready",  bus32.ready, 1);
    end
    bus32.start = 1'b0;

    run8("w8_mul",  4'b0000, 8'd15,  8'd17, 8'hFF, 8);
    run8("w8_divu", 4'b0001, 8'd255, 8'd16, 8'd15, 8);
    run8("w8_sra",  4'b0111, 8'h80,  8'd7,  8'hFF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
